// File: rtl/alu_pkg.sv
// Shared types and constants for the alu_muldiv datapath:
// ALU function codes, mul/div opcodes and the mul/div sequencer states.
package alu_pkg;

    localparam logic [2:0] ALU_F_AND  = 3'b000;
    localparam logic [2:0] ALU_F_OR   = 3'b001;
    localparam logic [2:0] ALU_F_ADD  = 3'b010;
    localparam logic [2:0] ALU_F_SLTU = 3'b011;
    localparam logic [2:0] ALU_F_NOR  = 3'b100;
    localparam logic [2:0] ALU_F_XOR  = 3'b101;
    localparam logic [2:0] ALU_F_SUB  = 3'b110;
    localparam logic [2:0] ALU_F_SLT  = 3'b111;

    typedef enum logic [2:0] {
        ALU_AND  = ALU_F_AND,
        ALU_OR   = ALU_F_OR,
        ALU_ADD  = ALU_F_ADD,
        ALU_SLTU = ALU_F_SLTU,
        ALU_NOR  = ALU_F_NOR,
        ALU_XOR  = ALU_F_XOR,
        ALU_SUB  = ALU_F_SUB,
        ALU_SLT  = ALU_F_SLT
    } alu_op_t;

    typedef enum logic [1:0] {
        MD_MULTU = 2'b00,
        MD_DIVU  = 2'b01,
        MD_MULT  = 2'b10,
        MD_DIV   = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_RUN  = 2'b01,
        MD_FIX  = 2'b10,
        MD_DONE = 2'b11
    } md_state_t;

endpackage

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide engine: shift-add multiply and restoring divide,
// one bit per cycle over WIDTH RUN cycles, then one FIX cycle for sign
// correction and the HI/LO write, then a one-cycle DONE pulse.
// Optional feature macro: ALU_MULDIV_SIGNED_EN enables MULT/DIV signed handling;
// without it MULT behaves as MULTU and DIV as DIVU.
module muldiv_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             md_start,
    input  logic [1:0]       md_op,
    output logic             md_busy,
    output logic             md_done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    md_state_t        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic             bz_q, bz_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;   // multiplicand or divisor magnitude
    logic [WIDTH-1:0] acc_q, acc_d;       // product high half or partial remainder
    logic [WIDTH-1:0] mq_q, mq_d;         // multiplier/product low half or dividend/quotient
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             dbz_q, dbz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    md_op_t           op_s;
    logic             is_div_op_s;
    logic             signed_op_s;
    logic [WIDTH:0]   add_s;
    logic [WIDTH:0]   shl_s;
    logic [WIDTH:0]   sub_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0] quo_s;
    logic [WIDTH-1:0] rem_s;

    assign op_s        = md_op_t'(md_op);
    assign is_div_op_s = (op_s == MD_DIVU) || (op_s == MD_DIV);

`ifdef ALU_MULDIV_SIGNED_EN
    assign signed_op_s = (op_s == MD_MULT) || (op_s == MD_DIV);
`else
    assign signed_op_s = 1'b0;
`endif

    // One iteration step: multiply add/shift and divide trial subtraction
    always_comb begin
        add_s = {1'b0, acc_q} + {1'b0, (mq_q[0] ? mcand_q : {WIDTH{1'b0}})};
        shl_s = {acc_q, mq_q[WIDTH-1]};
        sub_s = shl_s - {1'b0, mcand_q};
    end

    // Final results with sign correction; divide by zero forces an all-ones quotient
    always_comb begin
        prod_s = (sa_q ^ sb_q) ? -{acc_q, mq_q} : {acc_q, mq_q};
        quo_s  = bz_q ? {WIDTH{1'b1}} : ((sa_q ^ sb_q) ? -mq_q : mq_q);
        rem_s  = sa_q ? -acc_q : acc_q;
    end

    // Next-state logic of the sequencer
    always_comb begin
        state_d = state_q;
        case (state_q)
            MD_IDLE: begin
                if (md_start) begin
                    state_d = MD_RUN;
                end else begin
                    state_d = MD_IDLE;
                end
            end
            MD_RUN: begin
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = MD_FIX;
                end else begin
                    state_d = MD_RUN;
                end
            end
            MD_FIX:  state_d = MD_DONE;
            MD_DONE: state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    // Datapath register updates for each sequencer state
    always_comb begin
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        bz_d     = bz_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mq_d     = mq_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dbz_d    = dbz_q;
        case (state_q)
            MD_IDLE: begin
                if (md_start) begin
                    is_div_d = is_div_op_s;
                    sa_d     = signed_op_s & a[WIDTH-1];
                    sb_d     = signed_op_s & b[WIDTH-1];
                    bz_d     = is_div_op_s && (b == {WIDTH{1'b0}});
                    mq_d     = (signed_op_s && a[WIDTH-1]) ? -a : a;
                    mcand_d  = (signed_op_s && b[WIDTH-1]) ? -b : b;
                    acc_d    = {WIDTH{1'b0}};
                    cnt_d    = {CW{1'b0}};
                    dbz_d    = 1'b0;
                end else begin
                    cnt_d    = cnt_q;
                end
            end
            MD_RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (is_div_q) begin
                    // Restoring step: keep the shifted remainder when the trial goes negative
                    acc_d = sub_s[WIDTH] ? shl_s[WIDTH-1:0] : sub_s[WIDTH-1:0];
                    mq_d  = {mq_q[WIDTH-2:0], ~sub_s[WIDTH]};
                end else begin
                    acc_d = add_s[WIDTH:1];
                    mq_d  = {add_s[0], mq_q[WIDTH-1:1]};
                end
            end
            MD_FIX: begin
                if (is_div_q) begin
                    hi_d  = rem_s;
                    lo_d  = quo_s;
                    dbz_d = bz_q;
                end else begin
                    hi_d  = prod_s[2*WIDTH-1:WIDTH];
                    lo_d  = prod_s[WIDTH-1:0];
                    dbz_d = dbz_q;
                end
            end
            MD_DONE: begin
                cnt_d = cnt_q;
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    // Status outputs decoded from the upcoming state so they leave flops
    always_comb begin
        busy_d = (state_d == MD_RUN) || (state_d == MD_FIX);
        done_d = (state_d == MD_DONE);
    end

    // State and datapath registers with asynchronous reset (aborts any operation)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= MD_IDLE;
            cnt_q    <= {CW{1'b0}};
            is_div_q <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            bz_q     <= 1'b0;
            mcand_q  <= {WIDTH{1'b0}};
            acc_q    <= {WIDTH{1'b0}};
            mq_q     <= {WIDTH{1'b0}};
            hi_q     <= {WIDTH{1'b0}};
            lo_q     <= {WIDTH{1'b0}};
            dbz_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            bz_q     <= bz_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mq_q     <= mq_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dbz_q    <= dbz_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign md_busy     = busy_q;
    assign md_done     = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: rtl/alu_muldiv.sv
// Datapath ALU for the multi-cycle MIPS CPU: combinational ALU plus the
// sequential multiply/divide engine (muldiv_seq) that owns HI/LO.
// Optional feature macro: ALU_MULDIV_SIGNED_EN (signed MULT/DIV).
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       f,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             ovf,
    input  logic             md_start,
    input  logic [1:0]       md_op,
    output logic             md_busy,
    output logic             md_done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] diff_s;
    logic             slt_s;
    logic             sltu_s;

    assign sum_s  = a + b;
    assign diff_s = a + ~b + {{(WIDTH-1){1'b0}}, 1'b1};
    assign slt_s  = $signed(a) < $signed(b);
    assign sltu_s = a < b;

    // ALU result select; overflow flagged only for ADD/SUB, y always wraps
    always_comb begin
        y   = {WIDTH{1'b0}};
        ovf = 1'b0;
        case (alu_op_t'(f))
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_NOR:  y = ~(a | b);
            ALU_XOR:  y = a ^ b;
            ALU_ADD: begin
                y   = sum_s;
                ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                y   = diff_s;
                ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SLT:  y = {{(WIDTH-1){1'b0}}, slt_s};
            ALU_SLTU: y = {{(WIDTH-1){1'b0}}, sltu_s};
            default: begin
                y   = {WIDTH{1'b0}};
                ovf = 1'b0;
            end
        endcase
    end

    assign zero = (y == {WIDTH{1'b0}});

    muldiv_seq #(
        .WIDTH(WIDTH)
    ) u_muldiv_seq (
        .clk         (clk),
        .reset       (reset),
        .a           (a),
        .b           (b),
        .md_start    (md_start),
        .md_op       (md_op),
        .md_busy     (md_busy),
        .md_done     (md_done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv (WIDTH=32): ALU vector table, mul/div
// vector table with latency/busy checks, reset abort and ignored re-start.
module tb_alu_muldiv;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   f;
    logic [W-1:0] y;
    logic         zero;
    logic         ovf;
    logic         md_start;
    logic [1:0]   md_op;
    logic         md_busy;
    logic         md_done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div_by_zero;

    int errors = 0;
    int checks = 0;

    alu_muldiv #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .a           (a),
        .b           (b),
        .f           (f),
        .y           (y),
        .zero        (zero),
        .ovf         (ovf),
        .md_start    (md_start),
        .md_op       (md_op),
        .md_busy     (md_busy),
        .md_done     (md_done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   f;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] y;
        logic         zero;
        logic         ovf;
    } alu_vec_t;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } md_vec_t;

    alu_vec_t alu_tab[13];
    md_vec_t  md_tab[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_md(input string name, input md_vec_t v);
        int   done_at;
        logic busy_ok;
        @(negedge clk);
        md_op    = v.op;
        a        = v.a;
        b        = v.b;
        md_start = 1'b1;
        @(negedge clk);
        md_start = 1'b0;
        done_at  = 0;
        busy_ok  = 1'b1;
        for (int k = 1; k <= 40 && done_at == 0; k++) begin
            if (k > 1) @(negedge clk);
            if (md_done === 1'b1) done_at = k;
            else if (md_busy !== 1'b1) busy_ok = 1'b0;
        end
        check({name, " latency"}, done_at, 34);
        check({name, " busy"}, busy_ok, 1'b1);
        check({name, " busy@done"}, md_busy, 1'b0);
        check({name, " hi"}, hi, v.hi);
        check({name, " lo"}, lo, v.lo);
        check({name, " dbz"}, div_by_zero, v.dbz);
        @(negedge clk);
        check({name, " done pulse"}, md_done, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           ndone;
        logic [W-1:0] hi_s;
        logic [W-1:0] lo_s;

        alu_tab[0]  = '{3'b010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
        alu_tab[1]  = '{3'b110, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0};
        alu_tab[2]  = '{3'b111, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0};
        alu_tab[3]  = '{3'b011, 32'h80000000, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
        alu_tab[4]  = '{3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0};
        alu_tab[5]  = '{3'b001, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1'b0, 1'b0};
        alu_tab[6]  = '{3'b100, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0};
        alu_tab[7]  = '{3'b101, 32'hAAAAAAAA, 32'hFFFFFFFF, 32'h55555555, 1'b0, 1'b0};
        alu_tab[8]  = '{3'b110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1};
        alu_tab[9]  = '{3'b010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
        alu_tab[10] = '{3'b010, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1};
        alu_tab[11] = '{3'b111, 32'h00000001, 32'h80000000, 32'h00000000, 1'b1, 1'b0};
        alu_tab[12] = '{3'b101, 32'h7FFFFFFF, 32'h00000001, 32'h7FFFFFFE, 1'b0, 1'b0};

        md_tab[0] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        md_tab[1] = '{2'b01, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1};
        md_tab[2] = '{2'b01, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        md_tab[3] = '{2'b00, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
        md_tab[4] = '{2'b01, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};
`ifdef ALU_MULDIV_SIGNED_EN
        md_tab[5] = '{2'b10, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
        md_tab[6] = '{2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        md_tab[7] = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        md_tab[8] = '{2'b11, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        md_tab[9] = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
`else
        md_tab[5] = '{2'b10, 32'hFFFFFFFD, 32'd5,        32'h00000004, 32'hFFFFFFF1, 1'b0};
        md_tab[6] = '{2'b11, 32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, 1'b0};
        md_tab[7] = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0};
        md_tab[8] = '{2'b11, 32'd7,        32'hFFFFFFFE, 32'h00000007, 32'h00000000, 1'b0};
        md_tab[9] = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
`endif
        md_tab[10] = '{2'b11, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};

        // Reset state
        reset    = 1'b1;
        a        = '0;
        b        = '0;
        f        = 3'b000;
        md_start = 1'b0;
        md_op    = 2'b00;
        #1;
        check("reset busy", md_busy, 1'b0);
        check("reset done", md_done, 1'b0);
        check("reset hi", hi, 32'h0);
        check("reset lo", lo, 32'h0);
        check("reset dbz", div_by_zero, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Combinational ALU
        for (int i = 0; i < 13; i++) begin
            f = alu_tab[i].f;
            a = alu_tab[i].a;
            b = alu_tab[i].b;
            #1;
            check($sformatf("alu[%0d] y", i), y, alu_tab[i].y);
            check($sformatf("alu[%0d] zero", i), zero, alu_tab[i].zero);
            check($sformatf("alu[%0d] ovf", i), ovf, alu_tab[i].ovf);
        end

        // Mul/div vectors
        for (int i = 0; i < 11; i++) begin
            run_md($sformatf("md[%0d]", i), md_tab[i]);
        end

        // Reset during RUN cycle 10 aborts the operation
        @(negedge clk);
        md_op    = 2'b00;
        a        = 32'hFFFFFFFF;
        b        = 32'hFFFFFFFF;
        md_start = 1'b1;
        @(negedge clk);
        md_start = 1'b0;
        for (int k = 2; k <= 10; k++) @(negedge clk);
        check("pre-reset busy", md_busy, 1'b1);
        reset = 1'b1;
        #1;
        check("abort busy", md_busy, 1'b0);
        check("abort hi", hi, 32'h0);
        check("abort lo", lo, 32'h0);
        check("abort done", md_done, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (md_done === 1'b1) ndone++;
        end
        check("abort no done", ndone, 0);
        run_md("after abort", '{2'b00, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0});

        // Re-pulsed md_start while busy or done is ignored
        @(negedge clk);
        md_op    = 2'b01;
        a        = 32'd100;
        b        = 32'd7;
        md_start = 1'b1;
        ndone    = 0;
        hi_s     = '0;
        lo_s     = '0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (md_done === 1'b1) begin
                ndone++;
                hi_s = hi;
                lo_s = lo;
            end
            md_start = (k == 5) || (k == 33) || (k == 34);
            if (k == 5) begin
                md_op = 2'b00;
                a     = 32'd3;
                b     = 32'd9;
            end
            if (k == 10) check("hold lo", lo, 32'd15);
        end
        check("restart done count", ndone, 1);
        check("restart hi", hi_s, 32'd2);
        check("restart lo", lo_s, 32'd14);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
